// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage load/store responder backed by an internal
// word array, with WAIT_CYCLES wait states per access. `ready` is held low
// while an access is outstanding so that the pipeline stalls.
// Optional feature macro: DMEM_RESP_ERR_EN adds the `err` output, which flags
// an out-of-range address or a request with both enables set.
module data_mem_responder #(
    parameter int BASE_ADDR   = 1024,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready
`ifdef DMEM_RESP_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] BASE_L    = 32'(BASE_ADDR);
    localparam logic [31:0] SPAN_L    = 32'(4 * DEPTH);
    localparam logic        ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0]  CNT_LOAD  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [3:0]         cnt_r;
    logic [31:0]        addr_r;
    logic [31:0]        wdata_r;
    logic               op_wr_r;
    logic               op_rd_r;
    logic [31:0]        rdata_r;
    logic [31:0]        mem_r [DEPTH];

    logic               req_s;
    logic               accept_s;
    logic               access_s;
    logic               ready_s;
    logic [31:0]        acc_addr_s;
    logic [31:0]        acc_wdata_s;
    logic               acc_wr_s;
    logic               acc_rd_s;
    logic [31:0]        off_s;
    logic               in_range_s;
    logic [IDX_W-1:0]   idx_s;
    logic               mem_we_s;

    assign req_s = rd_en | wr_en;

    // With zero wait states the access happens on the accepting edge, so the
    // operands come straight from the inputs while IDLE and from the latches
    // otherwise.
    assign acc_addr_s  = (state_r == IDLE) ? address : addr_r;
    assign acc_wdata_s = (state_r == IDLE) ? wdata   : wdata_r;
    assign acc_wr_s    = (state_r == IDLE) ? wr_en   : op_wr_r;
    assign acc_rd_s    = (state_r == IDLE) ? rd_en   : op_rd_r;

    // An address below BASE wraps off_s to a huge value, so the span test
    // alone would reject it; the explicit lower bound keeps the intent clear.
    assign off_s      = acc_addr_s - BASE_L;
    assign in_range_s = (acc_addr_s >= BASE_L) && (off_s < SPAN_L);
    assign idx_s      = off_s[IDX_W+1:2];

    // Writes are gated by reset so that an access abandoned by reset can
    // never reach the array.
    assign mem_we_s = access_s & acc_wr_s & in_range_s & rst;

    assign rdata = rdata_r;
    assign ready = ready_s;

    // Next-state, accept/access strobes and ready decode.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        access_s     = 1'b0;
        ready_s      = 1'b0;
        case (state_r)
            IDLE: begin
                ready_s = ~req_s;
                if (req_s) begin
                    accept_s = 1'b1;
                    if (ZERO_WAIT) begin
                        access_s     = 1'b1;
                        state_next_s = DONE;
                    end else begin
                        state_next_s = BUSY;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == 4'd0) begin
                    access_s     = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                ready_s      = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, wait counter, request latches and read data register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            op_wr_r <= 1'b0;
            op_rd_r <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                addr_r  <= address;
                wdata_r <= wdata;
                op_wr_r <= wr_en;
                op_rd_r <= rd_en;
                cnt_r   <= CNT_LOAD;
            end else if ((state_r == BUSY) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
            // Both enables set means a write; rdata then keeps its value.
            if (access_s && acc_rd_s && !acc_wr_s) begin
                rdata_r <= in_range_s ? mem_r[idx_s] : 32'd0;
            end
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[idx_s] <= acc_wdata_s;
        end
    end

`ifdef DMEM_RESP_ERR_EN
    logic err_r;

    // Error flag is captured on the completing edge, so it is high only
    // during DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= access_s & (~in_range_s | (acc_rd_s & acc_wr_s));
        end
    end

    assign err = err_r;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder: one instance with four wait
// states (sel 0) and one with zero wait states (sel 1).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd4, wr4, ready4;
    logic [31:0] addr4, wd4, rdata4;
    logic        rd0, wr0, ready0;
    logic [31:0] addr0, wd0, rdata0;
`ifdef DMEM_RESP_ERR_EN
    logic        err4, err0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.BASE_ADDR(1024), .DEPTH(64), .WAIT_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .rd_en(rd4), .wr_en(wr4), .address(addr4),
        .wdata(wd4), .rdata(rdata4), .ready(ready4)
`ifdef DMEM_RESP_ERR_EN
        , .err(err4)
`endif
    );

    data_mem_responder #(.BASE_ADDR(1024), .DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .rd_en(rd0), .wr_en(wr0), .address(addr0),
        .wdata(wd0), .rdata(rdata0), .ready(ready0)
`ifdef DMEM_RESP_ERR_EN
        , .err(err0)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            rd4 = rd; wr4 = wr; addr4 = a; wd4 = d;
        end else begin
            rd0 = rd; wr0 = wr; addr0 = a; wd0 = d;
        end
    endtask

    task automatic get(input int sel, output logic rdy, output logic [31:0] rdat, output logic e);
        rdy  = (sel == 0) ? ready4 : ready0;
        rdat = (sel == 0) ? rdata4 : rdata0;
`ifdef DMEM_RESP_ERR_EN
        e = (sel == 0) ? err4 : err0;
`else
        e = 1'b0;
`endif
    endtask

    // Drives a request and holds it until ready returns high after a stall.
    // Returns the number of ready-low cycles, ready at the first sample, and
    // rdata/err seen in the DONE cycle. Ends at the DONE negedge.
    task automatic access(input int sel, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          output int stall, output logic first_rdy,
                          output logic [31:0] rd_done, output logic e_done);
        logic        rdy, e, seen, done;
        logic [31:0] rdat;
        drive(sel, rd, wr, a, d);
        stall = 0; seen = 1'b0; done = 1'b0; first_rdy = 1'b1;
        rd_done = 32'd0; e_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            get(sel, rdy, rdat, e);
            if (i == 0) first_rdy = rdy;
            if (!rdy) begin
                stall++;
                seen = 1'b1;
            end else if (seen) begin
                rd_done = rdat;
                e_done  = e;
                done    = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check_val("access_completes", {31'd0, done}, 32'd1);
    endtask

    // Deasserts the request; the following cycle must be IDLE with ready=1.
    task automatic idle_chk(input int sel, input string tag);
        logic        rdy, e;
        logic [31:0] rdat;
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        get(sel, rdy, rdat, e);
        check_val(tag, {31'd0, rdy}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        logic        fr, e;
        logic [31:0] rv;

        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        #12;
        check_val("rst_ready4", {31'd0, ready4}, 32'd1);
        check_val("rst_rdata4", rdata4, 32'd0);
        check_val("rst_ready0", {31'd0, ready0}, 32'd1);
        check_val("rst_rdata0", rdata0, 32'd0);
`ifdef DMEM_RESP_ERR_EN
        check_val("rst_err4", {31'd0, err4}, 32'd0);
`endif
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // Basic write then read, five-cycle stall each
        access(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, st, fr, rv, e);
        check_val("w1024_stall", 32'(st), 32'd5);
`ifdef DMEM_RESP_ERR_EN
        check_val("w1024_err", {31'd0, e}, 32'd0);
`endif
        idle_chk(0, "w1024_idle");
        access(0, 1'b1, 1'b0, 32'd1024, 32'd0, st, fr, rv, e);
        check_val("r1024_stall", 32'(st), 32'd5);
        check_val("r1024_data", rv, 32'hDEADBEEF);
        idle_chk(0, "r1024_idle");

        // Back-to-back: write held through DONE, then read via 1031 (word 1)
        access(0, 1'b0, 1'b1, 32'd1028, 32'h11, st, fr, rv, e);
        check_val("w1028_rdata_hold", rv, 32'hDEADBEEF);
        access(0, 1'b1, 1'b0, 32'd1031, 32'd0, st, fr, rv, e);
        check_val("b2b_first_ready", {31'd0, fr}, 32'd0);
        check_val("b2b_stall", 32'(st), 32'd5);
        check_val("b2b_data", rv, 32'h11);
        idle_chk(0, "b2b_idle");

        // Known contents for top word and word 3
        access(0, 1'b0, 1'b1, 32'd1276, 32'h0000A5A5, st, fr, rv, e);
        idle_chk(0, "w1276_idle");
        access(0, 1'b0, 1'b1, 32'd1036, 32'h33, st, fr, rv, e);
        idle_chk(0, "w1036_idle");

        // Out-of-range accesses
        access(0, 1'b0, 1'b1, 32'd1020, 32'h55, st, fr, rv, e);
        check_val("oor_w_stall", 32'(st), 32'd5);
`ifdef DMEM_RESP_ERR_EN
        check_val("oor_w_err", {31'd0, e}, 32'd1);
`endif
        idle_chk(0, "oor_w_idle");
        access(0, 1'b1, 1'b0, 32'd4096, 32'd0, st, fr, rv, e);
        check_val("oor_r4096_stall", 32'(st), 32'd5);
        check_val("oor_r4096_data", rv, 32'd0);
`ifdef DMEM_RESP_ERR_EN
        check_val("oor_r_err", {31'd0, e}, 32'd1);
`endif
        idle_chk(0, "oor_r_idle");
        access(0, 1'b1, 1'b0, 32'd1280, 32'd0, st, fr, rv, e);
        check_val("oor_r1280_data", rv, 32'd0);
        idle_chk(0, "r1280_idle");
        access(0, 1'b1, 1'b0, 32'd1276, 32'd0, st, fr, rv, e);
        check_val("r1276_data", rv, 32'h0000A5A5);
        idle_chk(0, "r1276_idle");
        access(0, 1'b1, 1'b0, 32'd1024, 32'd0, st, fr, rv, e);
        check_val("r1024_after_oor", rv, 32'hDEADBEEF);
        idle_chk(0, "r1024b_idle");

        // Inputs changed after one BUSY cycle: latched write still lands
        drive(0, 1'b0, 1'b1, 32'd1032, 32'h77);
        @(posedge clk); #1;
        @(posedge clk); #1;
        access(0, 1'b0, 1'b0, 32'd1036, 32'hFFFFFFFF, st, fr, rv, e);
        check_val("mid_chg_stall", 32'(st), 32'd3);
        idle_chk(0, "mid_chg_idle");
        access(0, 1'b1, 1'b0, 32'd1032, 32'd0, st, fr, rv, e);
        check_val("mid_chg_r1032", rv, 32'h77);
        idle_chk(0, "r1032_idle");
        access(0, 1'b1, 1'b0, 32'd1036, 32'd0, st, fr, rv, e);
        check_val("mid_chg_r1036", rv, 32'h33);
        idle_chk(0, "r1036_idle");

        // Reset in the middle of a write
        drive(0, 1'b0, 1'b1, 32'd1036, 32'h99);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check_val("midrst_ready", {31'd0, ready4}, 32'd1);
        check_val("midrst_rdata", rdata4, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        access(0, 1'b1, 1'b0, 32'd1036, 32'd0, st, fr, rv, e);
        check_val("midrst_r1036", rv, 32'h33);
        idle_chk(0, "midrst_idle");

        // Zero wait states
        access(1, 1'b0, 1'b1, 32'd1024, 32'h12345678, st, fr, rv, e);
        check_val("w0_stall", 32'(st), 32'd1);
        idle_chk(1, "w0_idle");
        access(1, 1'b1, 1'b0, 32'd1024, 32'd0, st, fr, rv, e);
        check_val("r0_stall", 32'(st), 32'd1);
        check_val("r0_data", rv, 32'h12345678);
        idle_chk(1, "r0_idle");
        access(1, 1'b1, 1'b1, 32'd1024, 32'h0000CAFE, st, fr, rv, e);
        check_val("both0_stall", 32'(st), 32'd1);
        check_val("both0_rdata_hold", rv, 32'h12345678);
`ifdef DMEM_RESP_ERR_EN
        check_val("both0_err", {31'd0, e}, 32'd1);
`endif
        idle_chk(1, "both0_idle");
        access(1, 1'b1, 1'b0, 32'd1024, 32'd0, st, fr, rv, e);
        check_val("both0_written", rv, 32'h0000CAFE);
        idle_chk(1, "r0b_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the pipeline's MEM-stage load/store interface.
- Accepts one read or write request at a time from the MEM stage and serves it from an internal word array after a configurable number of wait states.
- Drives `ready` low while a request is outstanding. The pipeline uses `ready` to freeze all stages until the access completes.
- Sits between MEM_STAGE (the initiator) and the data storage. It replaces the zero-latency combinational data memory.

Parameters:
- BASE_ADDR, 1024, byte address mapped to word 0 of the array.
- DEPTH, 64, number of 32-bit words in the array (power of 2).
- WAIT_CYCLES, 4, number of BUSY cycles per access; legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rd_en  input  1  read request from MEM stage.
- wr_en  input  1  write request from MEM stage.
- address  input  32  byte address (ALU result).
- wdata  input  32  store data (Val_Rm).
- rdata  output  32  load data; registered.
- ready  output  1  1 = no access pending or access completing this cycle; 0 = freeze pipeline.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, wait counter=0, rdata=0, latched address/data/op=0.
  - ready follows its IDLE equation.
  - Array contents are not reset.
- Index: idx = (address - BASE_ADDR) >> 2; low 2 bits are ignored.
  - In range iff BASE_ADDR <= address < BASE_ADDR + 4*DEPTH.
- States: IDLE, BUSY, DONE.
- IDLE:
  - ready = ~(rd_en | wr_en), combinational.
  - On request: latch address, wdata and op; load counter = WAIT_CYCLES-1; go to BUSY.
  - If WAIT_CYCLES=0, go directly to DONE.
- BUSY:
  - ready=0.
  - Counter decrements each cycle.
  - At counter==0: perform the access on the same edge and go to DONE.
  - Write: array[idx] <= latched wdata.
  - Read: rdata <= array[idx].
- DONE:
  - ready=1 for exactly one cycle.
  - Next state is always IDLE, even if a request is still asserted.
  - A request still asserted in that IDLE cycle is a new request.
- Latency: a request first seen at edge t gives ready=1 in cycle t+WAIT_CYCLES+1. The total stall is WAIT_CYCLES+1 cycles.
- Inputs that change during BUSY or DONE are ignored, including deassertion. A started access always completes; there is no abort.
- rd_en and wr_en both 1: the write is performed and rdata is unchanged.
- Out-of-range address:
  - Write is dropped.
  - Read returns rdata=0.
  - Latency is identical to an in-range access.
- rdata holds its value until the next completed read.
- Reset asserted mid-access:
  - The access is abandoned and state returns to IDLE.
  - A pending write is not performed.
  - Any array word not yet written keeps its old value.

Optional Feature:
- Macro DMEM_RESP_ERR_EN.
- Defined:
  - Adds output port `err` (1 bit, reset 0), valid only in DONE.
  - err=1 if the latched address was out of range, or if rd_en and wr_en were both 1 at acceptance.
  - err=0 in all other states.
- Not defined: port absent; behaviour otherwise identical.

Test Plan:
- Reset with WAIT_CYCLES=4, no request: ready=1, rdata=0.
- Write 0xDEADBEEF to 1024, held until ready: ready=0 for 5 cycles, then ready=1 for 1 cycle. Read 1024 then returns rdata=0xDEADBEEF in its DONE cycle with the same 5-cycle stall.
- Back-to-back requests:
  - Write 0x11 to 1028 held through DONE, then read 1028: second access starts in the IDLE cycle after DONE and returns 0x11.
  - Address 1031 also maps to word 1.
- Out-of-range:
  - Write 0x55 to 1020, then read 4096: rdata=0, latency unchanged, no array word modified.
  - With DMEM_RESP_ERR_EN: err=1 in both DONE cycles.
- Mid-access changes:
  - Drop wr_en and change address after 1 BUSY cycle: original write still lands at the latched address.
  - Assert rst=0 mid-BUSY on a write: state returns to IDLE, ready=1, target word keeps its old value.
- WAIT_CYCLES=0: request gives ready=0 for one cycle, then ready=1 in DONE. Both enables set: write performed, rdata unchanged.
